prt_filter_multi: RTL and testbench
===================================

# prt_filter_multi

Multi-channel protection qualifier/release-delay block for the CPLD protection path of the LLC resonant converter. Each channel filters a raw active-high fault input with a programmable assert qualification and release delay. Repeated trips latch the channel until software clears it. Per-channel and combined protect outputs feed the PWM shutdown logic, and the block records the first channel to trip.

## Interface
- CH, 4: number of protection channels (1..16)
- AW, 8: width of per-channel delay counter
- ASSERT_DLY, 3: consecutive high samples required to trip (1..2^AW-1)
- RELEASE_DLY, 150: consecutive low samples required to release (1..2^AW-1)
- RETRY_MAX, 3: trips allowed before a channel locks (1..15)
- IW, derived, $clog2(CH) with a minimum of 1: width of the first-fault index
- clk  in  1  system clock
- Rst_n  in  1  synchronous, active-low reset
- Prt  in  CH  raw fault inputs, active high, synchronous to clk
- Mask  in  CH  per-channel disable; 1 = channel ignored
- Clr  in  1  single-cycle pulse: clear locks, retry counts and first-fault record
- Prt_dly  out  CH  filtered protect per channel, 1 = protect
- Prt_any  out  1  OR of Prt_dly
- Latched  out  CH  channel is in LOCK
- First_idx  out  IW  index of first channel to trip since reset/Clr
- First_valid  out  1  First_idx is valid

## Operation
- Per-channel FSM states: IDLE, QUAL, TRIP, HOLD, LOCK. Each channel has an AW-bit counter `cnt` and a 4-bit retry counter `rty`.
- IDLE (Prt_dly=0): Prt=1 → QUAL with cnt=1. If ASSERT_DLY=1, Prt=1 goes directly to TRIP.
- QUAL (Prt_dly=0): Prt=1 increments cnt. When cnt+1 reaches ASSERT_DLY, go to TRIP. Prt=0 → IDLE with cnt=0, so glitches are rejected.
- TRIP (Prt_dly=1): entry from QUAL or IDLE increments rty. If the incremented rty reaches RETRY_MAX, go to LOCK instead. Prt=0 → HOLD with cnt=1.
- HOLD (Prt_dly=1): Prt=0 increments cnt. When cnt+1 reaches RELEASE_DLY, go to IDLE. Prt=1 → TRIP with cnt=0. This is an immediate re-trip, needs no qualification and does not increment rty.
- LOCK (Prt_dly=1, Latched=1): Prt is ignored. Clr → HOLD with cnt=0, so the release delay still applies.
- Mask=1 forces IDLE with cnt=0 from any state except LOCK. rty is unchanged.
- Clr zeroes rty on all channels and clears First_valid.
- First fault: on a cycle with First_valid=0 (or Clr=1), the lowest-index channel entering TRIP or LOCK from QUAL/IDLE is captured into First_idx, and First_valid is set. Capture has priority over Clr in the same cycle.
- Clr in the same cycle as a trip entry: rty clears first and then increments, so rty=1.
- Counters saturate and never wrap. rty saturates at RETRY_MAX.

## Timing
- Reset values:
  - all channels start in HOLD with cnt=0, so protect is asserted out of reset until inputs have been healthy for RELEASE_DLY cycles
  - Prt_dly = all 1
  - Prt_any = 1
  - Latched = 0
  - First_idx = 0
  - First_valid = 0
  - rty = 0
- All outputs are registered and updated on the same edge as the state change. Prt_any is computed from next-state, not from the lagged Prt_dly.
- Assert latency: if Prt is sampled high at edges k..k+ASSERT_DLY-1, Prt_dly=1 after edge k+ASSERT_DLY-1.
- Release latency: if Prt is sampled low at edges m..m+RELEASE_DLY-1, Prt_dly=0 after edge m+RELEASE_DLY-1.
- Rst_n overrides everything, including mid-QUAL, mid-HOLD and LOCK.

## Configuration
- PRT_LATCH_EN defined: rty counters, LOCK state, Latched and Clr lock-release logic are present.
- PRT_LATCH_EN undefined:
  - no rty counters and no LOCK state; channels never lock
  - Latched is tied to 0
  - Clr only clears First_valid
  - RETRY_MAX is ignored

## Structure
- Package prt_pkg holds:
  - the state enum (IDLE, QUAL, TRIP, HOLD, LOCK)
  - the rty width constant (4)
  - a clog2-with-min-1 function for IW
- Sub-module prt_chan holds one channel's FSM, cnt and rty. It is instantiated CH times via generate.
- The top level contains the OR reduction, the priority encoder for first-fault capture, and the First_idx/First_valid registers.

## Test plan
Parameters for all scenarios: CH=4, ASSERT_DLY=3, RELEASE_DLY=150, RETRY_MAX=3.

- Reset release: Prt=0 after reset → Prt_dly=4'hF and Prt_any=1 for exactly 150 edges, then 4'h0.
- Qualification:
  - Prt[1]=1 for 2 cycles, then 0 → Prt_dly[1] stays 0.
  - Prt[1]=1 for 3 cycles → Prt_dly[1]=1 after the 3rd edge, First_idx=1, First_valid=1.
- Re-trip: Prt[0] trips, goes low for 100 cycles, then high 1 cycle → Prt_dly[0] never drops, and rty[0] is unchanged (1).
- Lock: 3 full trip/release cycles on ch2 → Latched[2]=1 on the 3rd trip and Prt_dly[2] stays 1 with Prt[2]=0. Clr → Prt_dly[2] drops 150 cycles later and Latched[2]=0.
- Simultaneous events:
  - ch3 and ch1 qualify on the same edge → First_idx=1.
  - Clr coincident with a ch3 trip → First_idx=3, First_valid=1, rty[3]=1.
- Mask: Mask[0]=1 while ch0 is in TRIP → Prt_dly[0]=0 next edge. Mask applied while ch0 is in LOCK → ch0 stays latched.

Source files
------------

// File: rtl/prt_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// prt_pkg - shared state type, retry width and index-width helper for prt_filter_multi
// Rev 1.0 - initial release
// -----------------------------------------------------------------------------
package prt_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        QUAL = 3'd1,
        TRIP = 3'd2,
        HOLD = 3'd3,
        LOCK = 3'd4
    } prt_state_t;

    localparam int RTY_W = 4;

    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prt_chan.sv
`default_nettype none
// -----------------------------------------------------------------------------
// prt_chan - one protection channel: assert qualification, release delay, retry lock
// Rev 1.0 - initial release; retry/lock logic present only with PRT_LATCH_EN
// -----------------------------------------------------------------------------
module prt_chan
    import prt_pkg::*;
#(
    parameter int AW          = 8,
    parameter int ASSERT_DLY  = 3,
    parameter int RELEASE_DLY = 150,
    parameter int RETRY_MAX   = 3
) (
    input  logic clk,
    input  logic Rst_n,
    input  logic prt,
    input  logic mask,
    input  logic clr,
    output logic prt_dly,
    output logic latched,
    output logic trip_entry,
    output logic prot_nxt
);

    localparam logic [AW:0] ASSERT_THR  = (AW+1)'(ASSERT_DLY);
    localparam logic [AW:0] RELEASE_THR = (AW+1)'(RELEASE_DLY);
    localparam bit          ASSERT_ONE  = (ASSERT_DLY <= 1);
    localparam bit          RELEASE_ONE = (RELEASE_DLY <= 1);

    prt_state_t    state, state_nxt, entry_state;
    logic [AW-1:0] cnt, cnt_nxt, cnt_inc;
    logic [AW:0]   cnt_p1;

    assign cnt_p1  = {1'b0, cnt} + (AW+1)'(1);
    assign cnt_inc = (&cnt) ? cnt : cnt + AW'(1);

`ifdef PRT_LATCH_EN
    localparam logic [RTY_W-1:0] RTY_LIM = RTY_W'(RETRY_MAX);
    logic [RTY_W-1:0] rty, rty_base, rty_inc;

    // Clr zeroes first, so a trip in the same cycle counts as retry 1.
    assign rty_base    = clr ? '0 : rty;
    assign rty_inc     = (rty_base >= RTY_LIM) ? rty_base : rty_base + RTY_W'(1);
    assign entry_state = (rty_inc >= RTY_LIM) ? LOCK : TRIP;
`else
    logic unused_cfg;
    assign unused_cfg  = ^{clr, RETRY_MAX};
    assign entry_state = TRIP;
`endif

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        trip_entry = 1'b0;
        if (mask && (state != LOCK)) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (prt) begin
                        if (ASSERT_ONE) begin
                            state_nxt  = entry_state;
                            cnt_nxt    = '0;
                            trip_entry = 1'b1;
                        end else begin
                            state_nxt = QUAL;
                            cnt_nxt   = AW'(1);
                        end
                    end
                end
                QUAL: begin
                    if (!prt) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt_p1 >= ASSERT_THR) begin
                        state_nxt  = entry_state;
                        cnt_nxt    = '0;
                        trip_entry = 1'b1;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                TRIP: begin
                    if (!prt) begin
                        state_nxt = RELEASE_ONE ? IDLE : HOLD;
                        cnt_nxt   = RELEASE_ONE ? '0 : AW'(1);
                    end
                end
                HOLD: begin
                    // A fault during release re-trips at once without touching rty.
                    if (prt) begin
                        state_nxt = TRIP;
                        cnt_nxt   = '0;
                    end else if (cnt_p1 >= RELEASE_THR) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
`ifdef PRT_LATCH_EN
                LOCK: begin
                    if (clr) begin
                        state_nxt = HOLD;
                        cnt_nxt   = '0;
                    end
                end
`endif
                default: begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign prot_nxt = (state_nxt == TRIP) || (state_nxt == HOLD) || (state_nxt == LOCK);

    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            state   <= HOLD;
            cnt     <= '0;
            prt_dly <= 1'b1;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            prt_dly <= prot_nxt;
        end
    end

`ifdef PRT_LATCH_EN
    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            rty     <= '0;
            latched <= 1'b0;
        end else begin
            rty     <= trip_entry ? rty_inc : rty_base;
            latched <= (state_nxt == LOCK);
        end
    end
`else
    assign latched = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/prt_filter_multi.sv
`default_nettype none
// -----------------------------------------------------------------------------
// prt_filter_multi - multi-channel protection qualifier with first-fault capture
// Rev 1.0 - initial release; PRT_LATCH_EN enables retry counting and channel lock
// -----------------------------------------------------------------------------
module prt_filter_multi
    import prt_pkg::*;
#(
    parameter  int CH          = 4,
    parameter  int AW          = 8,
    parameter  int ASSERT_DLY  = 3,
    parameter  int RELEASE_DLY = 150,
    parameter  int RETRY_MAX   = 3,
    localparam int IW          = clog2_min1(CH)
) (
    input  logic          clk,
    input  logic          Rst_n,
    input  logic [CH-1:0] Prt,
    input  logic [CH-1:0] Mask,
    input  logic          Clr,
    output logic [CH-1:0] Prt_dly,
    output logic          Prt_any,
    output logic [CH-1:0] Latched,
    output logic [IW-1:0] First_idx,
    output logic          First_valid
);

    logic [CH-1:0] trip_entry;
    logic [CH-1:0] prot_nxt;
    logic [IW-1:0] first_sel;
    logic          capture;

    for (genvar i = 0; i < CH; i++) begin : g_chan
        prt_chan #(
            .AW          (AW),
            .ASSERT_DLY  (ASSERT_DLY),
            .RELEASE_DLY (RELEASE_DLY),
            .RETRY_MAX   (RETRY_MAX)
        ) u_chan (
            .clk        (clk),
            .Rst_n      (Rst_n),
            .prt        (Prt[i]),
            .mask       (Mask[i]),
            .clr        (Clr),
            .prt_dly    (Prt_dly[i]),
            .latched    (Latched[i]),
            .trip_entry (trip_entry[i]),
            .prot_nxt   (prot_nxt[i])
        );
    end

    // Lowest index wins when several channels trip on the same edge.
    always_comb begin
        first_sel = '0;
        for (int i = CH - 1; i >= 0; i--) begin
            if (trip_entry[i]) first_sel = IW'(i);
        end
    end

    assign capture = (|trip_entry) && (!First_valid || Clr);

    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            Prt_any     <= 1'b1;
            First_idx   <= '0;
            First_valid <= 1'b0;
        end else begin
            Prt_any <= |prot_nxt;
            if (capture) begin
                First_idx   <= first_sel;
                First_valid <= 1'b1;
            end else if (Clr) begin
                First_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prt_filter_multi.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_prt_filter_multi - scenario and randomized stimulus against a run-length reference model
// Rev 1.0 - initial release
// -----------------------------------------------------------------------------
module tb_prt_filter_multi;

    localparam int CH    = 4;
    localparam int AW    = 8;
    localparam int A_DLY = 3;
    localparam int R_DLY = 150;
    localparam int R_MAX = 3;
    localparam int IW    = 2;
`ifdef PRT_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          Rst_n;
    logic          Clr;
    logic [CH-1:0] Prt, Mask, Prt_dly, Latched;
    logic          Prt_any, First_valid;
    logic [IW-1:0] First_idx;

    int checks = 0;
    int errors = 0;

    // Reference model: protect flag, consecutive high/low run lengths, trip count, lock flag.
    bit m_prot[CH];
    bit m_lock[CH];
    int m_hi[CH];
    int m_lo[CH];
    int m_rty[CH];
    bit m_fv;
    int m_fidx;

    always #5 clk = ~clk;

    prt_filter_multi #(
        .CH          (CH),
        .AW          (AW),
        .ASSERT_DLY  (A_DLY),
        .RELEASE_DLY (R_DLY),
        .RETRY_MAX   (R_MAX)
    ) dut (
        .clk         (clk),
        .Rst_n       (Rst_n),
        .Prt         (Prt),
        .Mask        (Mask),
        .Clr         (Clr),
        .Prt_dly     (Prt_dly),
        .Prt_any     (Prt_any),
        .Latched     (Latched),
        .First_idx   (First_idx),
        .First_valid (First_valid)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, input logic [CH-1:0] p, input logic [CH-1:0] m,
                                input logic c);
        int first;
        first = -1;
        if (!r) begin
            for (int i = 0; i < CH; i++) begin
                m_prot[i] = 1'b1;
                m_lock[i] = 1'b0;
                m_hi[i]   = 0;
                m_lo[i]   = 0;
                m_rty[i]  = 0;
            end
            m_fv   = 1'b0;
            m_fidx = 0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (c) m_rty[i] = 0;
                if (m_lock[i]) begin
                    if (c) begin
                        m_lock[i] = 1'b0;
                        m_prot[i] = 1'b1;
                        m_lo[i]   = 0;
                    end
                end else if (m[i]) begin
                    m_prot[i] = 1'b0;
                    m_hi[i]   = 0;
                    m_lo[i]   = 0;
                end else if (!m_prot[i]) begin
                    if (p[i]) begin
                        m_hi[i]++;
                        if (m_hi[i] >= A_DLY) begin
                            m_hi[i]   = 0;
                            m_lo[i]   = 0;
                            m_prot[i] = 1'b1;
                            if (m_rty[i] < R_MAX) m_rty[i]++;
                            if (LATCH && m_rty[i] >= R_MAX) m_lock[i] = 1'b1;
                            if (first < 0) first = i;
                        end
                    end else begin
                        m_hi[i] = 0;
                    end
                end else begin
                    if (p[i]) begin
                        m_lo[i] = 0;
                    end else begin
                        m_lo[i]++;
                        if (m_lo[i] >= R_DLY) begin
                            m_prot[i] = 1'b0;
                            m_lo[i]   = 0;
                        end
                    end
                end
            end
            if (first >= 0 && (!m_fv || c)) begin
                m_fv   = 1'b1;
                m_fidx = first;
            end else if (c) begin
                m_fv = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        logic [CH-1:0] ed, el;
        for (int i = 0; i < CH; i++) begin
            ed[i] = m_prot[i];
            el[i] = m_lock[i];
        end
        check_val("prt_dly",     32'(Prt_dly),     32'(ed));
        check_val("prt_any",     32'(Prt_any),     32'(|ed));
        check_val("latched",     32'(Latched),     32'(el));
        check_val("first_valid", 32'(First_valid), 32'(m_fv));
        check_val("first_idx",   32'(First_idx),   m_fidx);
    endtask

    task automatic step(input logic r, input logic [CH-1:0] p, input logic [CH-1:0] m, input logic c);
        Rst_n = r;
        Prt   = p;
        Mask  = m;
        Clr   = c;
        @(posedge clk);
        model_update(r, p, m, c);
        #1;
        compare_all();
    endtask

    task automatic run(input int n, input logic [CH-1:0] p, input logic [CH-1:0] m, input logic c);
        for (int k = 0; k < n; k++) step(1'b1, p, m, c);
    endtask

    initial begin
        Rst_n = 1'b0;
        Prt   = '0;
        Mask  = '0;
        Clr   = 1'b0;
        repeat (3) step(1'b0, '0, '0, 1'b0);

        // Release out of reset, then qualification with a 2-cycle glitch and a real trip.
        run(160, 4'h0, 4'h0, 1'b0);
        run(2,   4'b0010, 4'h0, 1'b0);
        run(5,   4'h0, 4'h0, 1'b0);
        run(3,   4'b0010, 4'h0, 1'b0);
        run(155, 4'h0, 4'h0, 1'b0);

        // Re-trip of ch0 during its release window.
        run(3,   4'b0001, 4'h0, 1'b0);
        run(100, 4'h0, 4'h0, 1'b0);
        run(1,   4'b0001, 4'h0, 1'b0);
        run(155, 4'h0, 4'h0, 1'b0);

        // Three trips on ch2, hold in lock, then Clr and release.
        repeat (3) begin
            run(3,   4'b0100, 4'h0, 1'b0);
            run(155, 4'h0, 4'h0, 1'b0);
        end
        run(20,  4'h0, 4'h0, 1'b0);
        run(1,   4'h0, 4'h0, 1'b1);
        run(155, 4'h0, 4'h0, 1'b0);

        // Simultaneous ch3/ch1 qualification, then Clr coincident with a ch3 trip.
        run(1,   4'h0, 4'h0, 1'b1);
        run(3,   4'b1010, 4'h0, 1'b0);
        run(155, 4'h0, 4'h0, 1'b0);
        run(2,   4'b1000, 4'h0, 1'b0);
        run(1,   4'b1000, 4'h0, 1'b1);
        run(155, 4'h0, 4'h0, 1'b0);

        // Mask during trip, then mask while locked and a Clr under mask.
        run(3,   4'b0001, 4'h0, 1'b0);
        run(1,   4'b0001, 4'b0001, 1'b0);
        run(155, 4'h0, 4'h0, 1'b0);
        run(1,   4'h0, 4'h0, 1'b1);
        repeat (3) begin
            run(3,   4'b0001, 4'h0, 1'b0);
            run(155, 4'h0, 4'h0, 1'b0);
        end
        run(10,  4'h0, 4'b0001, 1'b0);
        run(1,   4'h0, 4'b0001, 1'b1);
        run(3,   4'h0, 4'h0, 1'b0);
        run(155, 4'h0, 4'h0, 1'b0);

        // Randomized segments with per-channel fault density, sporadic mask, Clr and reset.
        for (int seg = 0; seg < 30; seg++) begin
            int pct[CH];
            bit mseg;
            for (int i = 0; i < CH; i++) begin
                case ($urandom_range(0, 7))
                    0, 1, 2, 3: pct[i] = 0;
                    4:          pct[i] = 3;
                    5:          pct[i] = 30;
                    6:          pct[i] = 90;
                    default:    pct[i] = 100;
                endcase
            end
            mseg = ($urandom_range(0, 4) == 0);
            if (seg == 15) begin
                step(1'b0, 4'hF, 4'h0, 1'b0);
                step(1'b0, 4'h0, 4'h0, 1'b1);
            end
            for (int k = 0; k < 180; k++) begin
                logic [CH-1:0] p, m;
                logic          c;
                for (int i = 0; i < CH; i++) begin
                    p[i] = ($urandom_range(0, 99) < pct[i]);
                    m[i] = mseg && ($urandom_range(0, 7) == 0);
                end
                c = ($urandom_range(0, 79) == 0);
                step(1'b1, p, m, c);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
